cmp_serial_wide: RTL and testbench

CMP_SERIAL_WIDE -- requirements
Module: cmp_serial_wide

---
 rtl/cmp_pkg.sv | 40 ++++
 rtl/cmp4_cascade.sv | 26 ++
 rtl/cmp_serial_wide.sv | 100 ++++++++++
 tb/tb_cmp_serial_wide.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
//------------------------------------------------------------------------------
// cmp_pkg : shared types and constants for the serial nibble comparator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIN  = 2'd2;

   // Cascade state bit order is {GT, LT, EQ}
   typedef logic [2:0] casc_t;
   localparam casc_t CASC_GT   = 3'b100;
   localparam casc_t CASC_LT   = 3'b010;
   localparam casc_t CASC_EQ   = 3'b001;
   localparam casc_t CASC_NONE = 3'b000;
   localparam casc_t CASC_BOTH = 3'b110;

   // 74HC85 cascade-input decode: IAEB dominates, otherwise GT/LT pins map through
   function automatic casc_t casc_seed(input logic gb, input logic sb, input logic eb);
      casc_t s;
      if (eb)
         s = CASC_EQ;
      else begin
         case ({gb, sb})
            2'b10:   s = CASC_GT;
            2'b01:   s = CASC_LT;
            2'b11:   s = CASC_NONE;
            default: s = CASC_BOTH;
         endcase
      end
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmp4_cascade.sv
//------------------------------------------------------------------------------
// cmp4_cascade : combinational 4-bit magnitude step with cascade pass-through.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp4_cascade
   import cmp_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  casc_t      casc_in,
   output casc_t      casc_out
);

   always_comb begin
      casc_out = casc_in;
      if (a > b)
         casc_out = CASC_GT;
      else if (a < b)
         casc_out = CASC_LT;
   end

endmodule

`default_nettype wire

// File: rtl/cmp_serial_wide.sv
//------------------------------------------------------------------------------
// cmp_serial_wide : wide unsigned magnitude comparator, one nibble per cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_serial_wide
   import cmp_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 iagb,
   input  logic                 iasb,
   input  logic                 iaeb,
   output logic                 busy,
   output logic                 done,
   output logic                 qagb,
   output logic                 qasb,
   output logic                 qaeb
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   casc_t            r_casc;
   casc_t            w_casc_next;

   // Operands shift right each RUN cycle so the active nibble is always [3:0]
   cmp4_cascade u_step (
      .a        (r_a[3:0]),
      .b        (r_b[3:0]),
      .casc_in  (r_casc),
      .casc_out (w_casc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_casc  <= CASC_NONE;
         busy    <= 1'b0;
         done    <= 1'b0;
         qagb    <= 1'b0;
         qasb    <= 1'b0;
         qaeb    <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_casc  <= casc_seed(iagb, iasb, iaeb);
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_casc <= w_casc_next;
               r_a    <= {4'h0, r_a[W-1:4]};
               r_b    <= {4'h0, r_b[W-1:4]};
               if (r_idx == LAST_IDX) begin
                  // Result is committed on entry to FIN so it is visible with DONE
                  {qagb, qasb, qaeb} <= w_casc_next;
                  done    <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmp_serial_wide.sv
//------------------------------------------------------------------------------
// tb_cmp_serial_wide : directed self-checking bench for cmp_serial_wide.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmp_serial_wide;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        iagb = 1'b0;
   logic        iasb = 1'b0;
   logic        iaeb = 1'b1;
   logic        busy, done, qagb, qasb, qaeb;

   int total = 0;
   int bad   = 0;

   cmp_serial_wide #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .iagb  (iagb),
      .iasb  (iasb),
      .iaeb  (iaeb),
      .busy  (busy),
      .done  (done),
      .qagb  (qagb),
      .qasb  (qasb),
      .qaeb  (qaeb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One compare: START for one cycle, expect DONE exactly 5 cycles later
   task automatic run_check(input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic gb, input logic sb, input logic eb,
                            input logic [2:0] exp, input string tag);
      int n;
      @(negedge clk);
      a = ta; b = tb_v; iagb = gb; iasb = sb; iaeb = eb; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
      end
      chk({tag, "_latency"}, n, 5);
      chk({tag, "_busy"}, {31'b0, busy}, 1);
      chk({tag, "_result"}, {29'b0, qagb, qasb, qaeb}, {29'b0, exp});
      @(negedge clk);
      chk({tag, "_after"}, {30'b0, done, busy}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ndone, dcyc, viol, k;
      logic [2:0] q_at_done, prev;
      int dcy[4];
      logic [2:0] dq[4];

      // Reset values
      @(negedge clk);
      chk("rst_q", {29'b0, qagb, qasb, qaeb}, 1);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      @(negedge clk);
      rst = 1'b0;

      run_check(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 3'b001, "eq");
      run_check(16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 3'b100, "msb");
      run_check(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 3'b010, "lt");
      run_check(16'h00FF, 16'h00FF, 1'b1, 1'b1, 1'b0, 3'b000, "casc_none");
      run_check(16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 3'b110, "casc_both");
      run_check(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0, 3'b100, "casc_gt");
      run_check(16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 3'b100, "over_lt");
      run_check(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3'b010, "casc_lt");

      // START repeated in cycles 2 and 3 with new operands must be ignored
      @(negedge clk);
      a = 16'h0005; b = 16'h0003; iagb = 0; iasb = 0; iaeb = 1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ndone = 0; dcyc = 0; q_at_done = 3'b000;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (dcyc == 0) begin
               dcyc = i;
               q_at_done = {qagb, qasb, qaeb};
            end
         end
         if (i == 2 || i == 3) begin
            start = 1'b1; a = 16'h0001; b = 16'h0009;
         end else begin
            start = 1'b0;
         end
      end
      chk("restart_count", ndone, 1);
      chk("restart_cycle", dcyc, 5);
      chk("restart_result", {29'b0, q_at_done}, 32'h4);

      // Asynchronous reset in cycle 3 of a run
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_q", {29'b0, qagb, qasb, qaeb}, 1);
      chk("midrst_busy", {31'b0, busy}, 0);
      chk("midrst_done", {31'b0, done}, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midrst_nodone", ndone, 0);
      run_check(16'h0ABC, 16'h0ABD, 1'b0, 1'b0, 1'b1, 3'b010, "post_rst");

      // START held high: DONE every 6 cycles, outputs move only with DONE
      prev = {qagb, qasb, qaeb};
      viol = 0; k = 0;
      iagb = 0; iasb = 0; iaeb = 1; b = 16'h0010;
      for (int c = 0; c <= 18; c++) begin
         start = 1'b1;
         a = ((c % 4) < 2) ? 16'h0100 : 16'h0001;
         @(negedge clk);
         if (done) begin
            if (k < 4) begin
               dcy[k] = c + 1;
               dq[k] = {qagb, qasb, qaeb};
            end
            k++;
         end else if ({qagb, qasb, qaeb} != prev) begin
            viol++;
         end
         prev = {qagb, qasb, qaeb};
      end
      start = 1'b0;
      chk("b2b_count", k, 3);
      chk("b2b_d0", dcy[0], 5);
      chk("b2b_d1", dcy[1], 11);
      chk("b2b_d2", dcy[2], 17);
      chk("b2b_q0", {29'b0, dq[0]}, 32'h4);
      chk("b2b_q1", {29'b0, dq[1]}, 32'h2);
      chk("b2b_q2", {29'b0, dq[2]}, 32'h4);
      chk("b2b_stable", viol, 0);
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
